// File: rtl/sync_fifo_credit_mc_if.sv
// Push/pop handshake bundle for the multi-channel credit FIFO.
// The producer/consumer side uses master; the FIFO uses slave.
interface sync_fifo_credit_mc_if #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 32,
    parameter int CH_W   = $clog2(NUM_CH)
);
    logic              in_valid;
    logic [CH_W-1:0]   in_ch;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic [CH_W-1:0]   out_ch;
    logic [DATA_W-1:0] out_data;
    logic              out_ready;

    modport master (
        output in_valid, in_ch, in_data, out_ready,
        input  out_valid, out_ch, out_data
    );

    modport slave (
        input  in_valid, in_ch, in_data, out_ready,
        output out_valid, out_ch, out_data
    );
endinterface

// File: rtl/sync_fifo_credit_mc.sv
// Multi-channel credit-flow FIFO: NUM_CH rings of DEPTH words in one banked array,
// round-robin output, one credit pulse per pop and DEPTH initial credits after reset.
module sync_fifo_credit_mc #(
    parameter int NUM_CH   = 4,
    parameter int DEPTH    = 8,
    parameter int DATA_W   = 32,
    parameter int CH_W     = $clog2(NUM_CH),
    parameter int ADDR_W   = $clog2(DEPTH),
    parameter int CNT_W    = ADDR_W + 1,
    parameter int AFULL_TH = DEPTH - 2
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    sync_fifo_credit_mc_if.slave      bus,
    output logic [NUM_CH-1:0]         o_credit_pulse,
    output logic                      o_init_done,
    output logic [NUM_CH*CNT_W-1:0]   o_ch_count,
    output logic [NUM_CH-1:0]         o_ch_afull,
    output logic [NUM_CH-1:0]         o_ovf_err
);
    localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]  AFULL_CNT = CNT_W'(AFULL_TH);
    localparam logic [ADDR_W-1:0] INIT_LAST = ADDR_W'(DEPTH - 1);
    localparam logic [CH_W-1:0]   LAST_CH   = CH_W'(NUM_CH - 1);

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t                         r_state, w_state_nxt;
    logic [ADDR_W-1:0]              r_init_cnt;
    logic [DATA_W-1:0]              r_mem [NUM_CH*DEPTH];
    logic [NUM_CH-1:0][ADDR_W-1:0]  r_wr_ptr, r_rd_ptr;
    logic [NUM_CH-1:0][CNT_W-1:0]   r_cnt;
    logic [CH_W-1:0]                r_rr, w_sel;
    logic                           w_any, w_run, w_pop, w_push, w_room;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state    <= ST_INIT;
            r_init_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_INIT) r_init_cnt <= r_init_cnt + 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (r_state == ST_INIT && r_init_cnt == INIT_LAST) w_state_nxt = ST_RUN;
    end

    assign w_run       = (r_state == ST_RUN);
    assign o_init_done = w_run;

    // Priority starts at r_rr; the selection only moves without a pop when a
    // higher-priority channel becomes non-empty.
    always_comb begin
        int unsigned idx;
        idx   = 0;
        w_sel = '0;
        w_any = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            idx = (int'(r_rr) + i) % NUM_CH;
            if (!w_any && r_cnt[idx] != '0) begin
                w_any = 1'b1;
                w_sel = CH_W'(idx);
            end
        end
    end

    assign bus.out_valid = w_run && w_any;
    assign bus.out_ch    = w_sel;
    assign bus.out_data  = r_mem[{w_sel, r_rd_ptr[w_sel]}];

    assign w_pop  = bus.out_valid && bus.out_ready;
    // A full channel still accepts when its head leaves in the same cycle.
    assign w_room = (r_cnt[bus.in_ch] != FULL_CNT) || (w_pop && w_sel == bus.in_ch);
    assign w_push = w_run && bus.in_valid && w_room;

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[{bus.in_ch, r_wr_ptr[bus.in_ch]}] <= bus.in_data;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_cnt          <= '0;
            r_rr           <= '0;
            o_ovf_err      <= '0;
            o_credit_pulse <= '0;
        end else begin
            o_credit_pulse <= '0;
            if (!w_run)     o_credit_pulse <= '1;
            else if (w_pop) o_credit_pulse[w_sel] <= 1'b1;

            if (bus.in_valid && !w_push) o_ovf_err[bus.in_ch] <= 1'b1;
            if (w_push) r_wr_ptr[bus.in_ch] <= r_wr_ptr[bus.in_ch] + 1'b1;
            if (w_pop) begin
                r_rd_ptr[w_sel] <= r_rd_ptr[w_sel] + 1'b1;
                r_rr            <= (w_sel == LAST_CH) ? '0 : w_sel + 1'b1;
            end

            for (int c = 0; c < NUM_CH; c++) begin
                r_cnt[c] <= r_cnt[c]
                          + CNT_W'(w_push && bus.in_ch == CH_W'(c))
                          - CNT_W'(w_pop && w_sel == CH_W'(c));
            end
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_view
        assign o_ch_count[c*CNT_W +: CNT_W] = r_cnt[c];
        assign o_ch_afull[c]                = (r_cnt[c] >= AFULL_CNT);
    end
endmodule
